// File: rtl/ppu_cpu_port_pkg.sv
// dendy_ppu_pkg: register indices, DMA states and VRAM increments shared by the PPU CPU port
package dendy_ppu_pkg;
  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_MASK    = 3'd1;
  localparam logic [2:0] REG_STATUS  = 3'd2;
  localparam logic [2:0] REG_OAMADDR = 3'd3;
  localparam logic [2:0] REG_OAMDATA = 3'd4;
  localparam logic [2:0] REG_SCROLL  = 3'd5;
  localparam logic [2:0] REG_ADDR    = 3'd6;
  localparam logic [2:0] REG_DATA    = 3'd7;
  localparam logic [13:0] VRAM_INC_ACROSS = 14'd1;
  localparam logic [13:0] VRAM_INC_DOWN   = 14'd32;
  localparam logic [13:0] PAL_BASE        = 14'h3F00;
  typedef enum logic [1:0] {DMA_IDLE, DMA_ALIGN, DMA_READ, DMA_WRITE} dma_state_t;
endpackage

// File: rtl/ppu_cpu_port_if.sv
// ppu_cpu_port_if: 6502-side register window, DMA read port and halt/NMI lines
interface ppu_cpu_port_if;
  logic [2:0] cpu_a;
  logic cpu_sel, cpu_dma_sel, cpu_r, cpu_w;
  logic [7:0] cpu_d, cpu_q;
  logic nmi, cpu_halt;
  logic [15:0] dma_a;
  logic dma_rd;
  logic [7:0] dma_q;
  modport master(output cpu_a, cpu_sel, cpu_dma_sel, cpu_r, cpu_w, cpu_d, dma_q,
                 input cpu_q, nmi, cpu_halt, dma_a, dma_rd);
  modport slave(input cpu_a, cpu_sel, cpu_dma_sel, cpu_r, cpu_w, cpu_d, dma_q,
                output cpu_q, nmi, cpu_halt, dma_a, dma_rd);
endinterface

// File: rtl/ppu_cpu_port_oam_dma.sv
// ppu_oam_dma: sprite DMA FSM, one ALIGN cycle then DMA_LEN READ/WRITE pairs into OAM
module ppu_oam_dma
  import dendy_ppu_pkg::*;
#(
  parameter int DMA_LEN = 256
) (
  input  logic        clock25,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  page,
  input  logic [7:0]  oam_base,
  output logic        busy,
  output logic        dma_rd,
  output logic [15:0] dma_a,
  output logic        oam_w,
  output logic [7:0]  oam_a
);
  dma_state_t state, state_n;
  logic [7:0] pg, idx;
  logic last;
  assign last = idx == 8'(DMA_LEN - 1);
  always_ff @(posedge clock25) begin
    if (reset) begin
      state <= DMA_IDLE;
      pg <= '0;
      idx <= '0;
    end else begin
      state <= state_n;
      pg <= state == DMA_IDLE && start ? page : pg;
      idx <= state == DMA_WRITE ? idx + 8'd1 : (state == DMA_IDLE ? '0 : idx);
    end
  end
  always_comb begin
    state_n = state == DMA_IDLE  ? (start ? DMA_ALIGN : DMA_IDLE) :
              state == DMA_ALIGN ? DMA_READ :
              state == DMA_READ  ? DMA_WRITE :
              (last ? DMA_IDLE : DMA_READ);
    busy = state != DMA_IDLE;
    dma_rd = state == DMA_READ;
    dma_a = dma_rd ? {pg, idx} : '0;
    oam_w = state == DMA_WRITE;
    oam_a = oam_base + idx;
  end
endmodule

// File: rtl/ppu_cpu_port.sv
// ppu_cpu_port: PPU $2000-$2007 register port with optional $4014 OAM DMA (PPU_OAMDMA_EN)
module ppu_cpu_port
  import dendy_ppu_pkg::*;
#(
  parameter int DMA_LEN = 256
) (
  input  logic              clock25,
  input  logic              reset,
  ppu_cpu_port_if.slave     bus,
  input  logic              vblank,
  input  logic              sprite0,
  input  logic              overflow,
  output logic              vblank_clr,
  output logic [7:0]        ctrl,
  output logic [7:0]        mask,
  output logic [7:0]        scroll_x,
  output logic [7:0]        scroll_y,
  output logic [13:0]       vram_a,
  output logic [7:0]        vram_d,
  output logic              vram_w,
  input  logic [7:0]        vram_q,
  output logic [7:0]        oam_a,
  output logic [7:0]        oam_d,
  output logic              oam_w,
  input  logic [7:0]        oam_q
);
  logic idle, wr, rd, w_tog, rd_pend, oam_wr, dma_w;
  logic [5:0] t_hi;
  logic [13:0] vaddr, vram_wa, inc;
  logic [7:0] rbuf, oam_addr, oam_wa, oam_wd, dma_oa;
`ifdef PPU_OAMDMA_EN
  ppu_oam_dma #(.DMA_LEN(DMA_LEN)) u_dma (
    .clock25 (clock25),
    .reset   (reset),
    .start   (bus.cpu_dma_sel & bus.cpu_w & idle),
    .page    (bus.cpu_d),
    .oam_base(oam_addr),
    .busy    (bus.cpu_halt),
    .dma_rd  (bus.dma_rd),
    .dma_a   (bus.dma_a),
    .oam_w   (dma_w),
    .oam_a   (dma_oa)
  );
`else
  logic unused_dma;
  assign unused_dma = ^{bus.cpu_dma_sel, 32'(DMA_LEN)};
  assign bus.cpu_halt = 1'b0;
  assign bus.dma_rd = 1'b0;
  assign bus.dma_a = '0;
  assign dma_w = 1'b0;
  assign dma_oa = '0;
`endif
  always_comb begin
    idle = !bus.cpu_halt;
    wr = bus.cpu_sel & bus.cpu_w & idle;
    rd = bus.cpu_sel & bus.cpu_r & !bus.cpu_w & idle;
    inc = ctrl[2] ? VRAM_INC_DOWN : VRAM_INC_ACROSS;
    bus.nmi = ctrl[7] & vblank;
    vram_a = vram_w ? vram_wa : vaddr;
    oam_a = dma_w ? dma_oa : (oam_wr ? oam_wa : oam_addr);
    oam_d = dma_w ? bus.dma_q : oam_wd;
    oam_w = dma_w | oam_wr;
  end
  always_ff @(posedge clock25) begin
    if (reset) begin
      ctrl <= '0;
      mask <= '0;
      scroll_x <= '0;
      scroll_y <= '0;
      w_tog <= 1'b0;
      t_hi <= '0;
      vaddr <= '0;
      rbuf <= '0;
      oam_addr <= '0;
      bus.cpu_q <= '0;
      vblank_clr <= 1'b0;
      vram_w <= 1'b0;
      vram_wa <= '0;
      vram_d <= '0;
      oam_wr <= 1'b0;
      oam_wa <= '0;
      oam_wd <= '0;
      rd_pend <= 1'b0;
    end else begin
      vblank_clr <= rd && bus.cpu_a == REG_STATUS;
      vram_w <= wr && bus.cpu_a == REG_DATA;
      oam_wr <= wr && bus.cpu_a == REG_OAMDATA;
      rd_pend <= rd && bus.cpu_a == REG_DATA;
      if (wr) begin
        case (bus.cpu_a)
          REG_CTRL:    ctrl <= bus.cpu_d;
          REG_MASK:    mask <= bus.cpu_d;
          REG_OAMADDR: oam_addr <= bus.cpu_d;
          REG_OAMDATA: begin
            oam_wa <= oam_addr;
            oam_wd <= bus.cpu_d;
            oam_addr <= oam_addr + 8'd1;
          end
          REG_SCROLL: begin
            scroll_x <= w_tog ? scroll_x : bus.cpu_d;
            scroll_y <= w_tog ? bus.cpu_d : scroll_y;
            w_tog <= !w_tog;
          end
          REG_ADDR: begin
            t_hi <= w_tog ? t_hi : bus.cpu_d[5:0];
            vaddr <= w_tog ? {t_hi, bus.cpu_d} : vaddr;
            w_tog <= !w_tog;
          end
          REG_DATA: begin
            vram_wa <= vaddr;
            vram_d <= bus.cpu_d;
            vaddr <= vaddr + inc;
          end
          default: ;
        endcase
      end
      if (rd && bus.cpu_a == REG_STATUS) begin
        bus.cpu_q <= {vblank, sprite0, overflow, 5'b0};
        w_tog <= 1'b0;
      end
      if (rd && bus.cpu_a == REG_OAMDATA)
        bus.cpu_q <= oam_q;
      // $2007 read: address already stable, so vram_q is sampled one cycle after the strobe
      if (rd_pend) begin
        bus.cpu_q <= vaddr >= PAL_BASE ? vram_q : rbuf;
        rbuf <= vram_q;
        vaddr <= vaddr + inc;
      end
    end
  end
endmodule

// File: tb/tb_ppu_cpu_port.sv
// tb_ppu_cpu_port: table-driven register checks plus status, NMI and OAM DMA sequences
module tb_ppu_cpu_port;
  import dendy_ppu_pkg::*;
  typedef struct {
    logic        wr;
    logic [2:0]  a;
    logic [7:0]  d;
    logic        chk_q;
    logic [7:0]  q;
    logic [13:0] va;
  } vec_t;
  logic clock25 = 1'b0;
  logic reset = 1'b1;
  logic vblank, sprite0, overflow, vblank_clr, vram_w, oam_w;
  logic [7:0] ctrl, mask, scroll_x, scroll_y, vram_d, vram_q, oam_a, oam_d, oam_q;
  logic [13:0] vram_a;
  logic [7:0] vmem [16384];
  logic [7:0] omem [256];
  int checks = 0;
  int fails = 0;
  vec_t v[$];
  ppu_cpu_port_if bus();
  ppu_cpu_port dut (
    .clock25   (clock25),
    .reset     (reset),
    .bus       (bus.slave),
    .vblank    (vblank),
    .sprite0   (sprite0),
    .overflow  (overflow),
    .vblank_clr(vblank_clr),
    .ctrl      (ctrl),
    .mask      (mask),
    .scroll_x  (scroll_x),
    .scroll_y  (scroll_y),
    .vram_a    (vram_a),
    .vram_d    (vram_d),
    .vram_w    (vram_w),
    .vram_q    (vram_q),
    .oam_a     (oam_a),
    .oam_d     (oam_d),
    .oam_w     (oam_w),
    .oam_q     (oam_q)
  );
  always #20 clock25 = ~clock25;
  always @(posedge clock25) begin
    if (vram_w) vmem[vram_a] <= vram_d;
    vram_q <= vmem[vram_a];
    if (oam_w) omem[oam_a] <= oam_d;
    oam_q <= omem[oam_a];
    bus.dma_q <= bus.dma_a[15:8] == 8'h02 ? bus.dma_a[7:0] :
                 bus.dma_a[15:8] == 8'h03 ? ~bus.dma_a[7:0] : 8'hEE;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic acc(input logic wr, input logic [2:0] a, input logic [7:0] d);
    @(negedge clock25);
    bus.cpu_sel = 1'b1;
    bus.cpu_a = a;
    bus.cpu_d = d;
    bus.cpu_w = wr;
    bus.cpu_r = !wr;
    @(negedge clock25);
    bus.cpu_sel = 1'b0;
    bus.cpu_w = 1'b0;
    bus.cpu_r = 1'b0;
    repeat (2) @(negedge clock25);
  endtask
  task automatic dma_run(input logic [7:0] page, input int abort_at, output int n);
    @(negedge clock25);
    bus.cpu_dma_sel = 1'b1;
    bus.cpu_w = 1'b1;
    bus.cpu_d = page;
    @(negedge clock25);
    bus.cpu_dma_sel = 1'b0;
    bus.cpu_w = 1'b0;
    n = 0;
    while (bus.cpu_halt && n < 2000) begin
      n++;
      if (n == 50) begin
        bus.cpu_sel = 1'b1;
        bus.cpu_w = 1'b1;
        bus.cpu_a = REG_CTRL;
        bus.cpu_d = 8'hFF;
      end
      if (n == 51) begin
        bus.cpu_sel = 1'b0;
        bus.cpu_w = 1'b0;
      end
      if (n == abort_at) reset = 1'b1;
      @(negedge clock25);
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int n, errs, bad;
    {bus.cpu_sel, bus.cpu_dma_sel, bus.cpu_r, bus.cpu_w} = '0;
    bus.cpu_a = '0;
    bus.cpu_d = '0;
    {vblank, sprite0, overflow} = '0;
    v.push_back('{1'b1, REG_ADDR,    8'h21, 1'b0, 8'h00, 14'h0000});
    v.push_back('{1'b1, REG_ADDR,    8'h08, 1'b0, 8'h00, 14'h2108});
    v.push_back('{1'b1, REG_DATA,    8'h5A, 1'b0, 8'h00, 14'h2109});
    v.push_back('{1'b1, REG_CTRL,    8'h04, 1'b0, 8'h00, 14'h2109});
    v.push_back('{1'b1, REG_ADDR,    8'h3F, 1'b0, 8'h00, 14'h2109});
    v.push_back('{1'b1, REG_ADDR,    8'hF0, 1'b0, 8'h00, 14'h3FF0});
    v.push_back('{1'b1, REG_DATA,    8'hAB, 1'b0, 8'h00, 14'h0010});
    v.push_back('{1'b1, REG_CTRL,    8'h00, 1'b0, 8'h00, 14'h0010});
    v.push_back('{1'b1, REG_ADDR,    8'h20, 1'b0, 8'h00, 14'h0010});
    v.push_back('{1'b1, REG_ADDR,    8'h00, 1'b0, 8'h00, 14'h2000});
    v.push_back('{1'b1, REG_DATA,    8'h11, 1'b0, 8'h00, 14'h2001});
    v.push_back('{1'b1, REG_DATA,    8'h22, 1'b0, 8'h00, 14'h2002});
    v.push_back('{1'b1, REG_ADDR,    8'h20, 1'b0, 8'h00, 14'h2002});
    v.push_back('{1'b1, REG_ADDR,    8'h00, 1'b0, 8'h00, 14'h2000});
    v.push_back('{1'b0, REG_DATA,    8'h00, 1'b1, 8'h00, 14'h2001});
    v.push_back('{1'b0, REG_DATA,    8'h00, 1'b1, 8'h11, 14'h2002});
    v.push_back('{1'b1, REG_ADDR,    8'h3F, 1'b0, 8'h00, 14'h2002});
    v.push_back('{1'b1, REG_ADDR,    8'h00, 1'b0, 8'h00, 14'h3F00});
    v.push_back('{1'b1, REG_DATA,    8'h0C, 1'b0, 8'h00, 14'h3F01});
    v.push_back('{1'b1, REG_ADDR,    8'h3F, 1'b0, 8'h00, 14'h3F01});
    v.push_back('{1'b1, REG_ADDR,    8'h00, 1'b0, 8'h00, 14'h3F00});
    v.push_back('{1'b0, REG_DATA,    8'h00, 1'b1, 8'h0C, 14'h3F01});
    v.push_back('{1'b1, REG_ADDR,    8'h20, 1'b0, 8'h00, 14'h3F01});
    v.push_back('{1'b1, REG_ADDR,    8'h01, 1'b0, 8'h00, 14'h2001});
    v.push_back('{1'b0, REG_DATA,    8'h00, 1'b1, 8'h0C, 14'h2002});
    v.push_back('{1'b1, REG_OAMADDR, 8'h10, 1'b0, 8'h00, 14'h2002});
    v.push_back('{1'b1, REG_OAMDATA, 8'hAA, 1'b0, 8'h00, 14'h2002});
    v.push_back('{1'b1, REG_OAMADDR, 8'h10, 1'b0, 8'h00, 14'h2002});
    v.push_back('{1'b0, REG_OAMDATA, 8'h00, 1'b1, 8'hAA, 14'h2002});
    v.push_back('{1'b0, REG_OAMDATA, 8'h00, 1'b1, 8'hAA, 14'h2002});
    v.push_back('{1'b1, REG_OAMDATA, 8'hBB, 1'b0, 8'h00, 14'h2002});
    v.push_back('{1'b1, REG_OAMDATA, 8'hCC, 1'b0, 8'h00, 14'h2002});
    v.push_back('{1'b1, REG_OAMADDR, 8'h11, 1'b0, 8'h00, 14'h2002});
    v.push_back('{1'b0, REG_OAMDATA, 8'h00, 1'b1, 8'hCC, 14'h2002});
    v.push_back('{1'b1, REG_MASK,    8'h1E, 1'b0, 8'h00, 14'h2002});
    repeat (3) @(negedge clock25);
    chk("reset regs", {ctrl, mask, scroll_x, scroll_y}, 0);
    chk("reset q/vram", {1'b0, bus.cpu_q, vram_a, vram_d, vram_w}, 0);
    chk("reset oam", {15'd0, oam_a, oam_d, oam_w}, 0);
    chk("reset misc", {12'd0, vblank_clr, bus.nmi, bus.cpu_halt, bus.dma_rd, bus.dma_a}, 0);
    reset = 1'b0;
    foreach (v[i]) begin
      acc(v[i].wr, v[i].a, v[i].d);
      if (v[i].chk_q) chk($sformatf("vec%0d cpu_q", i), 32'(bus.cpu_q), 32'(v[i].q));
      chk($sformatf("vec%0d vaddr", i), 32'(vram_a), 32'(v[i].va));
    end
    chk("vram 2108", 32'(vmem[14'h2108]), 'h5A);
    chk("vram 3FF0", 32'(vmem[14'h3FF0]), 'hAB);
    chk("oam 10", 32'(omem[8'h10]), 'hBB);
    chk("mask", 32'(mask), 'h1E);
    vblank = 1'b1;
    sprite0 = 1'b1;
    acc(1'b1, REG_SCROLL, 8'h11);
    @(negedge clock25);
    bus.cpu_sel = 1'b1;
    bus.cpu_r = 1'b1;
    bus.cpu_a = REG_STATUS;
    @(negedge clock25);
    bus.cpu_sel = 1'b0;
    bus.cpu_r = 1'b0;
    chk("status q", 32'(bus.cpu_q), 'hC0);
    chk("vblank_clr pulse", 32'(vblank_clr), 1);
    @(negedge clock25);
    chk("vblank_clr end", 32'(vblank_clr), 0);
    @(negedge clock25);
    acc(1'b1, REG_SCROLL, 8'h77);
    acc(1'b1, REG_SCROLL, 8'h88);
    chk("scroll_x", 32'(scroll_x), 'h77);
    chk("scroll_y", 32'(scroll_y), 'h88);
    sprite0 = 1'b0;
    overflow = 1'b1;
    acc(1'b0, REG_STATUS, 8'h00);
    chk("status ovf", 32'(bus.cpu_q), 'hA0);
    @(negedge clock25);
    bus.cpu_sel = 1'b1;
    bus.cpu_r = 1'b1;
    bus.cpu_w = 1'b1;
    bus.cpu_a = REG_CTRL;
    bus.cpu_d = 8'h80;
    @(negedge clock25);
    {bus.cpu_sel, bus.cpu_r, bus.cpu_w} = '0;
    repeat (2) @(negedge clock25);
    chk("r+w is write", 32'(ctrl), 'h80);
    chk("nmi on", 32'(bus.nmi), 1);
    vblank = 1'b0;
    #1;
    chk("nmi off", 32'(bus.nmi), 0);
    acc(1'b1, REG_CTRL, 8'h00);
`ifdef PPU_OAMDMA_EN
    acc(1'b1, REG_OAMADDR, 8'h10);
    dma_run(8'h02, 0, n);
    chk("dma halt cycles", n, 513);
    chk("ctrl during dma", 32'(ctrl), 'h00);
    errs = 0;
    for (int i = 0; i < 256; i++) if (omem[8'(8'h10 + i)] !== 8'(i)) errs++;
    chk("dma data p02", errs, 0);
    acc(1'b1, REG_OAMDATA, 8'h5A);
    chk("oam_addr kept", 32'(omem[8'h10]), 'h5A);
    chk("oam 11 kept", 32'(omem[8'h11]), 'h01);
    dma_run(8'h02, 202, n);
    chk("abort cycle", n, 202);
    chk("abort halt", 32'(bus.cpu_halt), 0);
    chk("abort oam_w", 32'(oam_w), 0);
    reset = 1'b0;
    dma_run(8'h03, 0, n);
    chk("dma2 halt cycles", n, 513);
    errs = 0;
    for (int i = 0; i < 256; i++) if (omem[i] !== ~8'(i)) errs++;
    chk("dma data p03", errs, 0);
`else
    @(negedge clock25);
    bus.cpu_dma_sel = 1'b1;
    bus.cpu_w = 1'b1;
    bus.cpu_d = 8'h02;
    @(negedge clock25);
    bus.cpu_dma_sel = 1'b0;
    bus.cpu_w = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.cpu_halt || bus.dma_rd || bus.dma_a != 16'h0 || oam_w) bad++;
      @(negedge clock25);
    end
    chk("no dma activity", bad, 0);
    chk("oam 11 untouched", 32'(omem[8'h11]), 'hCC);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/ppu_cpu_port.md
# ppu_cpu_port

CPU-side register port of the Dendy PPU: decodes 6502 accesses to $2000–$2007 and $4014, holds PPUCTRL/PPUMASK/scroll state, and drives write traffic into video RAM and OAM ahead of the `ppu` renderer. It also runs sprite OAM DMA, which halts the CPU while copying 256 bytes from a CPU page into OAM. It sits between the CPU bus and the PPU memory ports (VRAM/CHR, OAM) in the top level.

## Interface
Parameters:
- DMA_LEN, 256, bytes copied per OAM DMA.

Ports:
- clock25  in  1  system clock (25 MHz)
- reset  in  1  synchronous, active-high reset
- cpu_a  in  3  register index (CPU A[2:0])
- cpu_sel  in  1  $2000–$2007 window selected
- cpu_dma_sel  in  1  $4014 selected
- cpu_r / cpu_w  in  1 each  one-cycle access strobes
- cpu_d  in  8  write data
- cpu_q  out  8  read data, registered
- nmi  out  1  level NMI request
- cpu_halt  out  1  CPU stall during DMA
- vblank, sprite0, overflow  in  1 each  status flags from `ppu`
- vblank_clr  out  1  one-cycle pulse clearing vblank in `ppu`
- ctrl, mask  out  8 each  PPUCTRL / PPUMASK
- scroll_x, scroll_y  out  8 each  $2005 values
- vram_a  out  14  VRAM/CHR/palette address
- vram_d  out  8, vram_w  out  1, vram_q  in  8
- oam_a  out  8, oam_d  out  8, oam_w  out  1, oam_q  in  8
- dma_a  out  16, dma_rd  out  1, dma_q  in  8  CPU-bus read port for DMA

## Operation
- Reset: all outputs 0; toggle w=0; read buffer 0; oam_addr 0; DMA FSM IDLE.
- Access accepted only when cpu_sel (or cpu_dma_sel) and strobe high and FSM IDLE; cpu_r and cpu_w together → write only.
- $2000 write → ctrl; $2001 → mask.
- $2002 read → cpu_q={vblank,sprite0,overflow,5'b0}; w←0; vblank_clr pulses next cycle.
- $2003 write → oam_addr. $2004 write → oam_w with oam_a=oam_addr, then oam_addr+1 (8-bit wrap). $2004 read → oam_q at oam_addr, no increment.
- $2005 write: w=0 → scroll_x, w=1 → scroll_y; w toggles.
- $2006 write: w=0 → t[13:8]=cpu_d[5:0]; w=1 → t[7:0]=cpu_d, vaddr←t; w toggles.
- $2007 write: vram_w pulse at vaddr; vaddr += ctrl[2] ? 32 : 1, 14-bit wrap ($3FFF+1 → $0000).
- $2007 read: vaddr < $3F00 → cpu_q = buffer, buffer ← vram_q; vaddr ≥ $3F00 → cpu_q = vram_q direct, buffer ← vram_q. Then vaddr increments as for write.
- nmi = ctrl[7] & vblank (combinational from registered ctrl).
- DMA FSM: IDLE → ALIGN (1 cycle) → READ/WRITE alternating, DMA_LEN pairs → IDLE. READ: dma_a={page,idx}, dma_rd=1. WRITE: oam_a=oam_addr+idx (wrap), oam_d=dma_q, oam_w=1. oam_addr unchanged after DMA.

## Timing
- vram_q/oam_q/dma_q valid one clock25 after address.
- Register writes take effect the cycle after cpu_w.
- cpu_q valid the cycle after cpu_r for $2002/$2004; two cycles after for $2007. CPU strobes are ≥3 cycles apart; closer strobes are undefined.
- DMA: cpu_halt high from the cycle after the $4014 write through the final WRITE; 1+2·DMA_LEN = 513 cycles. Strobes during DMA are ignored.
- Reset mid-DMA: FSM to IDLE, cpu_halt and oam_w low next cycle.

## Configuration
- PPU_OAMDMA_EN defined: DMA FSM present as described.
- Undefined: $4014 writes ignored; cpu_halt, dma_rd, dma_a tied 0; OAM writes only via $2004.

## Structure
- Package dendy_ppu_pkg: register index constants (REG_CTRL…REG_DATA), DMA state enum, VRAM increment constants.
- Sub-module ppu_oam_dma: FSM, idx counter, halt/dma_rd/oam write mux request. It sits under the PPU_OAMDMA_EN guard.

## Test plan
- Reset, then write $2006=$21, $2006=$08, $2007=$5A → vram_w at $2108, d=$5A; vaddr=$2109.
- ctrl[2]=1, vaddr=$3FF0, $2007 write → next address $0010 (wrap).
- vaddr=$2000 holding $11,$22: two $2007 reads → cpu_q = old buffer, then $11; palette $3F00=$0C read → $0C immediately.
- vblank=1, sprite0=1: $2002 read → cpu_q=$C0, vblank_clr one pulse, next $2005 write lands in scroll_x.
- oam_addr=$10, $4014 write $02 with CPU page $0200–$02FF = index → OAM[$10+i]=i (mod 256), cpu_halt high exactly 513 cycles.
- Reset asserted at DMA byte 100 → cpu_halt 0 next cycle; subsequent $4014 completes a full 513-cycle DMA.
